// File: rtl/pwm_decoder.sv
// Loop-back monitor for one transducer PWM channel: decodes each 512-tick TIME
// period into pulse width, first rise/fall times and edge-count flags.
module pwm_decoder #(
    parameter int ULTRASOUND_CNT_CYCLE = 512
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [8:0] TIME,
    input  logic       EN,
    input  logic       PWM_IN,
    output logic       VALID,
    output logic [9:0] WIDTH,
    output logic [8:0] RISE,
    output logic [8:0] FALL,
    output logic       NO_RISE,
    output logic       NO_FALL,
    output logic       MULTI_EDGE,
    output logic       TIME_ERR
);

    localparam logic [8:0] TIME_LAST = 9'(ULTRASOUND_CNT_CYCLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE} state_t;

    state_t     state_q,      state_d;
    logic       prev_q,       prev_d;
    logic [8:0] last_time_q,  last_time_d;
    logic [9:0] width_acc_q,  width_acc_d;
    logic [1:0] rise_cnt_q,   rise_cnt_d;
    logic [1:0] fall_cnt_q,   fall_cnt_d;
    logic [8:0] rise_acc_q,   rise_acc_d;
    logic [8:0] fall_acc_q,   fall_acc_d;
    logic       valid_q,      valid_d;
    logic [9:0] width_q,      width_d;
    logic [8:0] rise_q,       rise_d;
    logic [8:0] fall_q,       fall_d;
    logic       no_rise_q,    no_rise_d;
    logic       no_fall_q,    no_fall_d;
    logic       multi_q,      multi_d;
    logic       time_err_q,   time_err_d;

    logic       rise_edge, fall_edge, time_ok;
    logic [8:0] time_inc;
    logic [9:0] meas_width;
    logic [1:0] meas_rise_cnt, meas_fall_cnt;
    logic [8:0] meas_rise_acc, meas_fall_acc;

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d     = state_q;
        prev_d      = prev_q;
        last_time_d = TIME;
        width_acc_d = width_acc_q;
        rise_cnt_d  = rise_cnt_q;
        fall_cnt_d  = fall_cnt_q;
        rise_acc_d  = rise_acc_q;
        fall_acc_d  = fall_acc_q;
        valid_d     = 1'b0;
        width_d     = width_q;
        rise_d      = rise_q;
        fall_d      = fall_q;
        no_rise_d   = no_rise_q;
        no_fall_d   = no_fall_q;
        multi_d     = multi_q;
        time_err_d  = time_err_q;

        time_inc      = last_time_q + 9'd1;
        time_ok       = (TIME == time_inc);
        rise_edge     = PWM_IN & ~prev_q;
        fall_edge     = ~PWM_IN & prev_q;
        meas_width    = width_acc_q + {9'd0, PWM_IN};
        meas_rise_cnt = (rise_edge && rise_cnt_q != 2'd2) ? rise_cnt_q + 2'd1 : rise_cnt_q;
        meas_fall_cnt = (fall_edge && fall_cnt_q != 2'd2) ? fall_cnt_q + 2'd1 : fall_cnt_q;
        meas_rise_acc = (rise_edge && rise_cnt_q == 2'd0) ? TIME : rise_acc_q;
        meas_fall_acc = (fall_edge && fall_cnt_q == 2'd0) ? TIME : fall_acc_q;

        unique case (state_q)
            S_IDLE: begin
                if (EN) state_d = S_ARM;
            end
            S_ARM: begin
                if (!time_ok) begin
                    time_err_d = 1'b1;
                end else if (TIME == TIME_LAST) begin
                    prev_d  = PWM_IN;
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (!time_ok) begin
                    time_err_d = 1'b1;
                    state_d    = S_ARM;
                    width_acc_d = '0;
                    rise_cnt_d  = '0;
                    fall_cnt_d  = '0;
                    rise_acc_d  = '0;
                    fall_acc_d  = '0;
                end else begin
                    prev_d      = PWM_IN;
                    width_acc_d = meas_width;
                    rise_cnt_d  = meas_rise_cnt;
                    fall_cnt_d  = meas_fall_cnt;
                    rise_acc_d  = meas_rise_acc;
                    fall_acc_d  = meas_fall_acc;
                    // Report overlaps the first sample of the next period, so the
                    // accumulators restart from zero while results are registered.
                    if (TIME == TIME_LAST) begin
                        valid_d     = 1'b1;
                        width_d     = meas_width;
                        no_rise_d   = (meas_rise_cnt == 2'd0);
                        no_fall_d   = (meas_fall_cnt == 2'd0);
                        rise_d      = (meas_rise_cnt == 2'd0) ? 9'd0 : meas_rise_acc;
                        fall_d      = (meas_fall_cnt == 2'd0) ? 9'd0 : meas_fall_acc;
                        multi_d     = (meas_rise_cnt == 2'd2) || (meas_fall_cnt == 2'd2);
                        width_acc_d = '0;
                        rise_cnt_d  = '0;
                        fall_cnt_d  = '0;
                        rise_acc_d  = '0;
                        fall_acc_d  = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!EN) begin
            state_d     = S_IDLE;
            valid_d     = 1'b0;
            time_err_d  = 1'b0;
            width_acc_d = '0;
            rise_cnt_d  = '0;
            fall_cnt_d  = '0;
            rise_acc_d  = '0;
            fall_acc_d  = '0;
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            prev_q      <= 1'b0;
            last_time_q <= '0;
            width_acc_q <= '0;
            rise_cnt_q  <= '0;
            fall_cnt_q  <= '0;
            rise_acc_q  <= '0;
            fall_acc_q  <= '0;
            valid_q     <= 1'b0;
            width_q     <= '0;
            rise_q      <= '0;
            fall_q      <= '0;
            no_rise_q   <= 1'b0;
            no_fall_q   <= 1'b0;
            multi_q     <= 1'b0;
            time_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            last_time_q <= last_time_d;
            width_acc_q <= width_acc_d;
            rise_cnt_q  <= rise_cnt_d;
            fall_cnt_q  <= fall_cnt_d;
            rise_acc_q  <= rise_acc_d;
            fall_acc_q  <= fall_acc_d;
            valid_q     <= valid_d;
            width_q     <= width_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            no_rise_q   <= no_rise_d;
            no_fall_q   <= no_fall_d;
            multi_q     <= multi_d;
            time_err_q  <= time_err_d;
        end
    end

    assign VALID      = valid_q;
    assign WIDTH      = width_q;
    assign RISE       = rise_q;
    assign FALL       = fall_q;
    assign NO_RISE    = no_rise_q;
    assign NO_FALL    = no_fall_q;
    assign MULTI_EDGE = multi_q;
    assign TIME_ERR   = time_err_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: TIME counter and PWM patterns generated here,
// expected results hand-computed per pattern.
module tb_pwm_decoder;

    logic       CLK = 1'b0;
    logic       RST, EN, PWM_IN;
    logic [8:0] TIME;
    logic       VALID, NO_RISE, NO_FALL, MULTI_EDGE, TIME_ERR;
    logic [9:0] WIDTH;
    logic [8:0] RISE, FALL;

    pwm_decoder #(.ULTRASOUND_CNT_CYCLE(512)) dut (
        .CLK(CLK), .RST(RST), .TIME(TIME), .EN(EN), .PWM_IN(PWM_IN),
        .VALID(VALID), .WIDTH(WIDTH), .RISE(RISE), .FALL(FALL),
        .NO_RISE(NO_RISE), .NO_FALL(NO_FALL), .MULTI_EDGE(MULTI_EDGE),
        .TIME_ERR(TIME_ERR)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int t_nxt = 0;
    int mode  = 0;
    int n;

    // 0: 100..227  1: 480..31 wrap  2: high  3: low  4: 10..19 and 300..309
    function automatic logic pat(input int m, input int t);
        case (m)
            0:       return (t >= 100 && t <= 227);
            1:       return (t >= 480 || t <= 31);
            2:       return 1'b1;
            4:       return (t >= 10 && t <= 19) || (t >= 300 && t <= 309);
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        TIME   = 9'(t_nxt);
        PWM_IN = pat(mode, t_nxt);
        @(posedge CLK);
        #1;
        t_nxt = (t_nxt + 1) % 512;
    endtask

    task automatic wait_valid(input string tag, input int budget, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!VALID && cnt < budget);
        check({tag, "_valid"}, VALID, 1);
    endtask

    task automatic check_out(input string tag, input int w, input int r, input int f,
                             input int nr, input int nf, input int me);
        check({tag, "_width"}, WIDTH, w);
        check({tag, "_rise"},  RISE,  r);
        check({tag, "_fall"},  FALL,  f);
        check({tag, "_norise"}, NO_RISE, nr);
        check({tag, "_nofall"}, NO_FALL, nf);
        check({tag, "_multi"}, MULTI_EDGE, me);
    endtask

    // First period after a pattern change straddles two patterns; check the second.
    task automatic run_pattern(input string tag, input int m, input int w, input int r,
                               input int f, input int nr, input int nf, input int me);
        int c;
        mode = m;
        wait_valid({tag, "_warm"}, 600, c);
        wait_valid(tag, 600, c);
        check({tag, "_period"}, c, 512);
        check_out(tag, w, r, f, nr, nf, me);
    endtask

    initial begin
        RST = 1'b1;
        EN  = 1'b0;
        step();
        step();
        check("rst_valid", VALID, 0);
        check("rst_width", WIDTH, 0);
        check("rst_err", TIME_ERR, 0);
        check("rst_flags", {NO_RISE, NO_FALL, MULTI_EDGE}, 0);
        check("rst_edges", {RISE, FALL}, 0);

        RST   = 1'b0;
        EN    = 1'b1;
        t_nxt = 0;
        mode  = 0;
        wait_valid("first", 1100, n);
        check("first_latency", n, 1024);
        check_out("first", 128, 100, 228, 0, 0, 0);
        step();
        check("strobe_len", VALID, 0);
        wait_valid("second", 600, n);
        check("second_period", n + 1, 512);
        check_out("second", 128, 100, 228, 0, 0, 0);

        run_pattern("wrap", 1, 64, 480, 32, 0, 0, 0);
        run_pattern("high", 2, 512, 0, 0, 1, 1, 0);
        run_pattern("low",  3, 0,   0, 0, 1, 1, 0);
        run_pattern("two",  4, 20, 10, 20, 0, 0, 1);

        // TIME jump 200 -> 205 inside MEASURE
        mode = 0;
        wait_valid("pre_jump", 600, n);
        while (t_nxt <= 200) step();
        t_nxt = 205;
        step();
        check("jump_err", TIME_ERR, 1);
        check("jump_novalid", VALID, 0);
        wait_valid("post_jump", 1000, n);
        check("post_jump_latency", n, 818);
        check_out("post_jump", 128, 100, 228, 0, 0, 0);
        check("post_jump_err", TIME_ERR, 1);
        EN = 1'b0;
        step();
        EN = 1'b1;
        check("en_clears_err", TIME_ERR, 0);

        // RST at TIME 300
        wait_valid("pre_rst", 1200, n);
        while (t_nxt < 300) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("midrst_valid", VALID, 0);
        check_out("midrst", 0, 0, 0, 0, 0, 0);
        wait_valid("post_rst", 1000, n);
        check("post_rst_latency", n, 723);
        check_out("post_rst", 128, 100, 228, 0, 0, 0);

        // EN dropped at TIME 300
        while (t_nxt < 300) step();
        EN = 1'b0;
        step();
        EN = 1'b1;
        check("en_drop_valid", VALID, 0);
        check("en_drop_hold", WIDTH, 128);
        wait_valid("post_en", 1000, n);
        check("post_en_latency", n, 723);
        check_out("post_en", 128, 100, 228, 0, 0, 0);

        // RST and EN low together: reset wins, outputs cleared
        RST = 1'b1;
        EN  = 1'b0;
        step();
        RST = 1'b0;
        check("rst_en_width", WIDTH, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
